// File: rtl/stream_demux_1to4.sv
// Registered 1-to-4 stream demultiplexer. Each output channel has a one-entry
// register with its own backpressure and a wrapping delivered-word counter.
module stream_demux_1to4 #(
   parameter int WIDTH = 5,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic [1:0]       sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] data_out0,
   output logic [WIDTH-1:0] data_out1,
   output logic [WIDTH-1:0] data_out2,
   output logic [WIDTH-1:0] data_out3,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
   output logic [CNT_W-1:0] count0,
   output logic [CNT_W-1:0] count1,
   output logic [CNT_W-1:0] count2,
   output logic [CNT_W-1:0] count3
);

   // Handshakes: a word moves on a cycle where valid and ready are both high;
   // in_ready depends on rst, sel and the selected channel only, never on in_valid.
   typedef enum logic {CH_EMPTY = 1'b0, CH_FULL = 1'b1} ch_state_e;

   ch_state_e        state_q [4];
   ch_state_e        state_d [4];
   logic [WIDTH-1:0] data_q  [4];
   logic [WIDTH-1:0] data_d  [4];
   logic [CNT_W-1:0] cnt_q   [4];
   logic [CNT_W-1:0] cnt_d   [4];
   logic [3:0]       deliver;
   logic             accept;

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         out_valid[k] = (state_q[k] == CH_FULL);
      end
   end

   assign deliver  = out_valid & out_ready;
   assign in_ready = !rst && (!out_valid[sel] || out_ready[sel]);
   assign accept   = in_valid && in_ready;

   // A new word for a channel wins over its delivery, so a deliver+accept
   // cycle reloads the register with no bubble.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         state_d[k] = state_q[k];
         data_d[k]  = data_q[k];
         cnt_d[k]   = cnt_q[k];
         if (accept && (sel == 2'(k))) begin
            state_d[k] = CH_FULL;
            data_d[k]  = data_in;
         end else if (deliver[k]) begin
            state_d[k] = CH_EMPTY;
         end
         if (deliver[k]) begin
            cnt_d[k] = cnt_q[k] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            state_q[k] <= CH_EMPTY;
            data_q[k]  <= '0;
            cnt_q[k]   <= '0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            state_q[k] <= state_d[k];
            data_q[k]  <= data_d[k];
            cnt_q[k]   <= cnt_d[k];
         end
      end
   end

   assign data_out0 = data_q[0];
   assign data_out1 = data_q[1];
   assign data_out2 = data_q[2];
   assign data_out3 = data_q[3];
   assign count0    = cnt_q[0];
   assign count1    = cnt_q[1];
   assign count2    = cnt_q[2];
   assign count3    = cnt_q[3];

endmodule

// File: tb/tb_stream_demux_1to4.sv
// Directed bench for stream_demux_1to4: reset, routing, backpressure isolation,
// streaming, counter wrap and mid-operation reset.
module tb_stream_demux_1to4;

   localparam int WIDTH = 5;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] data_in;
   logic [1:0]       sel;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] data_out0, data_out1, data_out2, data_out3;
   logic [3:0]       out_valid;
   logic [3:0]       out_ready;
   logic [CNT_W-1:0] count0, count1, count2, count3;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   stream_demux_1to4 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .sel(sel),
      .in_valid(in_valid), .in_ready(in_ready),
      .data_out0(data_out0), .data_out1(data_out1),
      .data_out2(data_out2), .data_out3(data_out3),
      .out_valid(out_valid), .out_ready(out_ready),
      .count0(count0), .count1(count1), .count2(count2), .count3(count3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_counts(input string tag, input int c0, input int c1, input int c2, input int c3);
      check({tag, "_count0"}, 32'(count0), 32'(c0));
      check({tag, "_count1"}, 32'(count1), 32'(c1));
      check({tag, "_count2"}, 32'(count2), 32'(c2));
      check({tag, "_count3"}, 32'(count3), 32'(c3));
   endtask

   initial begin
      // Reset with traffic offered
      rst = 1'b1; in_valid = 1'b1; out_ready = 4'hF; sel = 2'd0; data_in = 5'b10101;
      tick();
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_data_out0", 32'(data_out0), 32'd0);
      check("rst_data_out3", 32'(data_out3), 32'd0);
      check_counts("rst", 0, 0, 0, 0);

      // Routing to channel 2
      rst = 1'b0; out_ready = 4'h0; sel = 2'd2; data_in = 5'b11000; in_valid = 1'b1;
      #1;
      check("route_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      check("route_out_valid", 32'(out_valid), 32'b0100);
      check("route_data_out2", 32'(data_out2), 32'b11000);

      // Backpressure isolation: channel 2 stalled, channel 0 still open
      sel = 2'd2; data_in = 5'b10101; in_valid = 1'b1;
      #1;
      check("bp_sel2_in_ready", 32'(in_ready), 32'd0);
      tick();
      sel = 2'd0; data_in = 5'b00001;
      #1;
      check("bp_sel0_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      check("bp_out_valid", 32'(out_valid), 32'b0101);
      check("bp_data_out0", 32'(data_out0), 32'b00001);
      check("bp_data_out2", 32'(data_out2), 32'b11000);
      check_counts("bp", 0, 0, 0, 0);

      // Drain both held words
      out_ready = 4'hF;
      tick();
      check("drain_out_valid", 32'(out_valid), 32'd0);
      check("drain_data_out2_held", 32'(data_out2), 32'b11000);
      check_counts("drain", 1, 0, 1, 0);

      // Back-to-back streaming on channel 3
      sel = 2'd3;
      for (int i = 0; i < 10; i++) begin
         data_in = 5'(i); in_valid = 1'b1;
         #1;
         check($sformatf("stream_in_ready_%0d", i), 32'(in_ready), 32'd1);
         tick();
         check($sformatf("stream_data_out3_%0d", i), 32'(data_out3), 32'(i));
         check($sformatf("stream_valid3_%0d", i), 32'(out_valid[3]), 32'd1);
      end
      in_valid = 1'b0;
      tick();
      check("stream_out_valid", 32'(out_valid), 32'd0);
      check_counts("stream", 1, 0, 1, 10);

      // Counter wrap on channel 1
      sel = 2'd1; in_valid = 1'b1;
      for (int i = 0; i < 256; i++) begin
         data_in = 5'(i);
         tick();
      end
      in_valid = 1'b0;
      check("wrap_count1_255", 32'(count1), 32'd255);
      check("wrap_data_out1", 32'(data_out1), 32'd31);
      tick();
      check_counts("wrap", 1, 0, 1, 10);

      // Mid-operation reset with channels 0 and 3 full
      out_ready = 4'h0; in_valid = 1'b1;
      sel = 2'd0; data_in = 5'd7;
      tick();
      sel = 2'd3; data_in = 5'd9;
      tick();
      in_valid = 1'b0;
      check("mid_out_valid", 32'(out_valid), 32'b1001);
      rst = 1'b1; out_ready = 4'hF; sel = 2'd1;
      #1;
      check("mid_rst_in_ready", 32'(in_ready), 32'd0);
      tick();
      rst = 1'b0; out_ready = 4'h0;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_data_out0", 32'(data_out0), 32'd0);
      check_counts("mid_rst", 0, 0, 0, 0);
      sel = 2'd1; data_in = 5'h1F; in_valid = 1'b1;
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      check("post_rst_out_valid", 32'(out_valid), 32'b0010);
      check("post_rst_data_out1", 32'(data_out1), 32'h1F);
      out_ready = 4'b0010;
      tick();
      check("post_rst_delivered", 32'(out_valid), 32'd0);
      check_counts("post_rst", 0, 1, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
